// File: rtl/cond_logic_1_if.sv
// Decoder-to-conditional-unit bundle: condition field, ALU flags, write requests and gated strobes.
// SkipCount/SkipClr exist only when COND_SKIP_CNT_EN is defined.
interface cond_logic_1_if;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic        NoWrite;
    logic        Stall;
    logic        CondEx;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic [3:0]  Flags;
`ifdef COND_SKIP_CNT_EN
    logic [15:0] SkipCount;
    logic        SkipClr;
`endif

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
`ifdef COND_SKIP_CNT_EN
        output SkipClr,
        input  SkipCount,
`endif
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
`ifdef COND_SKIP_CNT_EN
        input  SkipClr,
        output SkipCount,
`endif
        output CondEx, PCSrc, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/cond_logic_1.sv
// ARM conditional-execution unit: NZCV flag register, condition evaluation and write-strobe gating.
// Optional squashed-instruction counter enabled by COND_SKIP_CNT_EN.
module cond_logic_1 (
    input logic          clk,
    input logic          reset_n,
    cond_logic_1_if.slave bus
);
    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] flags_q;
    logic              cond_ex_c;
    logic [1:0]        flag_write_c;
    logic              n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Condition is judged on the stored flags, never on this cycle's ALU result
    always_comb begin
        cond_ex_c = 1'b0;
        unique case (bus.Cond)
            4'b0000: cond_ex_c = z;
            4'b0001: cond_ex_c = ~z;
            4'b0010: cond_ex_c = c;
            4'b0011: cond_ex_c = ~c;
            4'b0100: cond_ex_c = n;
            4'b0101: cond_ex_c = ~n;
            4'b0110: cond_ex_c = v;
            4'b0111: cond_ex_c = ~v;
            4'b1000: cond_ex_c = c & ~z;
            4'b1001: cond_ex_c = ~c | z;
            4'b1010: cond_ex_c = (n == v);
            4'b1011: cond_ex_c = (n != v);
            4'b1100: cond_ex_c = ~z & (n == v);
            4'b1101: cond_ex_c = z | (n != v);
            4'b1110: cond_ex_c = 1'b1;
            default: cond_ex_c = 1'b0;
        endcase
    end

    assign flag_write_c = bus.FlagW & {2{cond_ex_c}} & {2{~bus.Stall}};

    assign bus.CondEx   = cond_ex_c;
    assign bus.PCSrc    = bus.PCS  & cond_ex_c & ~bus.Stall;
    assign bus.RegWrite = bus.RegW & cond_ex_c & ~bus.NoWrite & ~bus.Stall;
    assign bus.MemWrite = bus.MemW & cond_ex_c & ~bus.Stall;
    assign bus.Flags    = flags_q;

    // N,Z and C,V halves load independently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            if (flag_write_c[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (flag_write_c[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

`ifdef COND_SKIP_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] skip_cnt_q;

    // Clear wins over increment; count saturates rather than wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_cnt_q <= '0;
        end else if (bus.SkipClr) begin
            skip_cnt_q <= '0;
        end else if (!bus.Stall && !cond_ex_c && (skip_cnt_q != {CNT_W{1'b1}})) begin
            skip_cnt_q <= skip_cnt_q + CNT_W'(1);
        end
    end

    assign bus.SkipCount = skip_cnt_q;
`endif

endmodule

// File: doc/cond_logic_1.md
# cond_logic_1

Conditional-execution unit for the single-cycle ARM datapath; the consumer of the `FlagW` and `NoWrite` controls produced by the ALU decoder.
- Holds the architectural N, Z, C and V flags in a register, split into two independently written halves.
- Evaluates the 4-bit `Cond` field of the current instruction against the stored flags.
- Gates the datapath write strobes (`PCSrc`, `RegWrite`, `MemWrite`) so that condition-failed instructions are squashed.
- Sits between the control decoder and the register file, memory and PC mux.

## Interface
Parameters:
- none (widths fixed by the ISA)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- Cond  in  4  Instr[31:28] condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  in  2  from ALU decoder: [1] requests an N,Z write; [0] requests a C,V write
- PCS  in  1  decoder request to write the PC
- RegW  in  1  decoder request to write the register file
- MemW  in  1  decoder request to write data memory
- NoWrite  in  1  from ALU decoder, set for compare-type ops (CMP/CMN/TST/TEQ); suppresses the register write
- Stall  in  1  freezes state and suppresses all strobes
- CondEx  out  1  condition passed (combinational)
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- Flags  out  4  registered {N,Z,C,V}
- SkipCount  out  16  squashed-instruction counter (only with COND_SKIP_CNT_EN)
- SkipClr  in  1  synchronous clear of SkipCount (only with COND_SKIP_CNT_EN)

## Operation
CondEx is evaluated on the registered Flags, never on ALUFlags:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C&~Z
- 1001 LS: ~C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: ~Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0 (unsupported encoding, always squashed)

Flag writes:
- Write enables: FlagWrite[1:0] = FlagW & {2{CondEx}} & {2{~Stall}}.
- FlagWrite[1] loads Flags[3:2] ← ALUFlags[3:2] (N,Z).
- FlagWrite[0] loads Flags[1:0] ← ALUFlags[1:0] (C,V).
- The two halves are independent; a half whose enable is low holds its value.

Strobes:
- PCSrc = PCS & CondEx & ~Stall
- RegWrite = RegW & CondEx & ~NoWrite & ~Stall
- MemWrite = MemW & CondEx & ~Stall

A failed condition blocks both the strobes and the flag write of that instruction.

## Timing
- Reset (reset_n=0, asynchronous): Flags=4'b0000, SkipCount=0.
  - With Flags=0: EQ fails, NE passes, AL passes.
- CondEx and all strobes are combinational from the current Cond, Flags and controls; zero latency.
- A flag update becomes visible at the next rising edge. An instruction never sees its own flag write; the following instruction does (1-cycle effective latency).
- Stall=1: Flags and SkipCount hold, all strobes are 0, CondEx still reflects the evaluation.
- Reset asserted mid-cycle: Flags clear immediately, and the strobes follow the reset-valued flags in the same cycle.
- Reset release: the first rising edge with reset_n=1 is the first edge that may update state.

## Configuration
COND_SKIP_CNT_EN:
- Defined:
  - SkipCount and SkipClr exist.
  - On each rising edge with Stall=0 and CondEx=0, SkipCount increments, saturating at 16'hFFFF (no wrap).
  - SkipClr=1 clears the counter at the edge and takes priority over an increment in the same cycle.
- Undefined:
  - Both ports and the counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then Cond=0000, RegW=1 → CondEx=0, RegWrite=0. Same with Cond=0001 → RegWrite=1. Cond=1111 → CondEx=0.
- Cond=1110, FlagW=11, ALUFlags=0100, edge → Flags=0100. Next cycle Cond=0000, MemW=1 → MemWrite=1.
- Split write:
  - Flags=1111.
  - Cond=1110, FlagW=10, ALUFlags=0000, edge → Flags=0011 (C,V kept).
  - Then FlagW=01, ALUFlags=0000, edge → Flags=0000.
- Squashed flag write: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, edge → Flags stay 0000, all strobes 0.
- Stall and NoWrite:
  - Stall=1, Cond=1110, PCS=RegW=MemW=1, FlagW=11 → strobes 0, Flags unchanged across the edge.
  - Stall=0, NoWrite=1 → RegWrite=0, PCSrc=1, MemWrite=1.
- (COND_SKIP_CNT_EN) Counter:
  - Hold Cond=1111 for 3 edges → SkipCount=3.
  - SkipClr=1 together with a failing condition → SkipCount=0.
  - Force the count to 16'hFFFF and apply a further failing condition → stays 16'hFFFF.
